// File: rtl/draw_rect_char.sv
// -----------------------------------------------------------------------------
// draw_rect_char
//
// Overlays a 16x16-cell text block (8x16-pixel glyphs, 128x256 pixels) onto
// a VGA-style pixel stream.  The text block's top-left corner is at
// (X_POS, Y_POS).  The module addresses an external char ROM (char_xy) and an
// external font ROM (char_line -> char_pixels), each with one cycle of read
// latency.  The pixel stream is delayed four cycles so the overlay decision
// lines up with the returned glyph row.
//
// Timing, for a pixel presented on the inputs in cycle N:
//   N+1  char_xy registered (cell column/row)
//   N+2  char_line registered (glyph row), aligned with the char ROM output
//   N+3  char_pixels expected on the input (font ROM output)
//   N+4  all *_out registered, rgb_out carries the overlay
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   hcount_in/vcount_in pixel position from the upstream timing stage
//   hsync_in/vsync_in   upstream syncs
//   hblnk_in/vblnk_in   upstream blanking
//   rgb_in              upstream RGB444 colour
//   char_xy             cell address to char ROM: [7:4] column, [3:0] row
//   char_line           glyph row to font ROM
//   char_pixels         glyph row bitmap, bit 7 = leftmost pixel
//   *_out               delayed stream with the text overlay applied
//
// Build option:
//   DRAW_RECT_CHAR_BG_EN  when defined, glyph-background pixels inside the
//                         text block are painted BG_COLOR; otherwise the
//                         background is transparent (rgb_in shows through).
//
// This block has no handshake and no FSM; every register advances every
// clock cycle.
// -----------------------------------------------------------------------------
module draw_rect_char #(
  parameter logic [10:0] X_POS      = 11'd32,
  parameter logic [10:0] Y_POS      = 11'd32,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } px_t;

  // Position relative to the text block; wraps for pixels left of / above
  // the block, which is why in_rect also compares against X_POS/Y_POS.
  logic [10:0] rel_x;
  logic [10:0] rel_y;
  logic        in_rect;

  assign rel_x   = hcount_in - X_POS;
  assign rel_y   = vcount_in - Y_POS;
  assign in_rect = (hcount_in >= X_POS) && (rel_x < 11'd128) &&
                   (vcount_in >= Y_POS) && (rel_y < 11'd256);

  // Three-deep delay lines; the output register forms the fourth stage.
  px_t        px_d  [0:2];
  logic [2:0] col_d [0:2];
  logic       in_d  [0:2];
  logic [3:0] line_d1;

  // Overlay decision for the pixel leaving stage 3.
  logic        pix_on;
  logic        blank;
  logic [11:0] rgb_next;

  assign pix_on = char_pixels[3'd7 - col_d[2]];
  assign blank  = px_d[2].hblnk | px_d[2].vblnk;

  always_comb begin
    rgb_next = px_d[2].rgb;
    if (in_d[2] && !blank) begin
      if (pix_on) begin
        rgb_next = TEXT_COLOR;
      end else begin
`ifdef DRAW_RECT_CHAR_BG_EN
        rgb_next = BG_COLOR;
`else
        rgb_next = px_d[2].rgb;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      char_xy    <= '0;
      line_d1    <= '0;
      char_line  <= '0;
      for (int i = 0; i < 3; i++) begin
        px_d[i]  <= '0;
        col_d[i] <= '0;
        in_d[i]  <= 1'b0;
      end
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      // Stage 1: address the char ROM every cycle, in or out of the block.
      char_xy  <= {rel_x[6:3], rel_y[7:4]};
      line_d1  <= rel_y[3:0];
      px_d[0]  <= '{hcount: hcount_in, vcount: vcount_in,
                    hsync: hsync_in, vsync: vsync_in,
                    hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
      col_d[0] <= rel_x[2:0];
      in_d[0]  <= in_rect;

      // Stage 2: glyph row lines up with the char ROM's code output.
      char_line <= line_d1;
      px_d[1]   <= px_d[0];
      col_d[1]  <= col_d[0];
      in_d[1]   <= in_d[0];

      // Stage 3: font ROM returns char_pixels during this stage.
      px_d[2]   <= px_d[1];
      col_d[2]  <= col_d[1];
      in_d[2]   <= in_d[1];

      // Stage 4: registered outputs.
      hcount_out <= px_d[2].hcount;
      vcount_out <= px_d[2].vcount;
      hsync_out  <= px_d[2].hsync;
      vsync_out  <= px_d[2].vsync;
      hblnk_out  <= px_d[2].hblnk;
      vblnk_out  <= px_d[2].vblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_rect_char.sv
// -----------------------------------------------------------------------------
// tb_draw_rect_char
//
// Directed testbench for draw_rect_char with default parameters
// (text block at 32,32, TEXT_COLOR FFF, BG_COLOR 000).  Inputs are driven
// 1 ns after the rising edge and outputs are sampled at the same point, so
// a value presented before tick k is seen at the outputs after tick k+3.
// -----------------------------------------------------------------------------
module tb_draw_rect_char;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  draw_rect_char dut (
    .clk         (clk),
    .rst         (rst),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .hblnk_in    (hblnk_in),
    .vblnk_in    (vblnk_in),
    .rgb_in      (rgb_in),
    .char_xy     (char_xy),
    .char_line   (char_line),
    .char_pixels (char_pixels),
    .hcount_out  (hcount_out),
    .vcount_out  (vcount_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .hblnk_out   (hblnk_out),
    .vblnk_out   (vblnk_out),
    .rgb_out     (rgb_out)
  );

  // --------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hcount_in = 11'd0;
    vcount_in = 11'd0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    hblnk_in  = 1'b0;
    vblnk_in  = 1'b0;
    rgb_in    = 12'h000;
  endtask

  // Presents one pixel for a single cycle, then idles (0,0 lies outside the
  // block).  The font ROM row is only valid in the cycle before the output
  // edge, so a misaligned sample sees 8'h00.  Returns rgb_out after tick 4.
  task automatic run_pixel(input logic [10:0] h, input logic [10:0] v,
                           input logic [11:0] rgb, input logic hb,
                           input logic vb, input logic [7:0] pixels,
                           output logic [11:0] rgb_seen);
    hcount_in   = h;
    vcount_in   = v;
    rgb_in      = rgb;
    hblnk_in    = hb;
    vblnk_in    = vb;
    char_pixels = 8'h00;
    tick();
    set_idle();
    tick();
    tick();
    char_pixels = pixels;
    tick();
    rgb_seen    = rgb_out;
    char_pixels = 8'h00;
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst         = 1'b1;
    set_idle();
    hcount_in   = 11'd100;
    vcount_in   = 11'd50;
    rgb_in      = 12'hABC;
    hsync_in    = 1'b1;
    char_pixels = 8'hFF;
    tick();
    tick();
    checks++;
    if ({char_xy, char_line} !== 12'h000) begin
      errors++;
      $display("FAIL reset_rom_addr: char_xy=%h char_line=%h, want 00/0", char_xy, char_line);
    end
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h, want all 0",
               hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== '0) begin
      errors++;
      $display("FAIL reset_cycle_after: hc=%0d hs=%b rgb=%h, want all 0",
               hcount_out, hsync_out, rgb_out);
    end
    set_idle();
    char_pixels = 8'h00;
    repeat (4) tick();
  endtask

  task automatic test_char_addr();
    // rel_x = 29 -> column 3, rel_y = 39 -> row 2, line 7
    hcount_in = 11'd61;
    vcount_in = 11'd71;
    tick();
    checks++;
    if (char_xy !== 8'h32) begin
      errors++;
      $display("FAIL char_xy: got %h, want 32", char_xy);
    end
    set_idle();
    tick();
    checks++;
    if (char_line !== 4'd7) begin
      errors++;
      $display("FAIL char_line: got %0d, want 7", char_line);
    end
    repeat (3) tick();
  endtask

  task automatic test_passthrough();
    hcount_in = 11'd10;
    vcount_in = 11'd10;
    rgb_in    = 12'h0A5;
    hsync_in  = 1'b1;
    tick();
    set_idle();
    hcount_in = 11'd11;
    tick();
    tick();
    checks++;
    if (hsync_out !== 1'b0) begin
      errors++;
      $display("FAIL hsync_early: got %b at N+3, want 0", hsync_out);
    end
    tick();
    checks++;
    if ({hsync_out, rgb_out} !== {1'b1, 12'h0A5}) begin
      errors++;
      $display("FAIL passthrough_n4: hsync=%b rgb=%h, want 1/0a5", hsync_out, rgb_out);
    end
    checks++;
    if ({hcount_out, vcount_out} !== {11'd10, 11'd10}) begin
      errors++;
      $display("FAIL passthrough_pos: hc=%0d vc=%0d, want 10/10", hcount_out, vcount_out);
    end
    tick();
    checks++;
    if ({hsync_out, hcount_out} !== {1'b0, 11'd11}) begin
      errors++;
      $display("FAIL hsync_late: hsync=%b hc=%0d, want 0/11", hsync_out, hcount_out);
    end
    set_idle();
    repeat (4) tick();
  endtask

  task automatic test_glyph();
    logic [11:0] seen;
    logic [11:0] exp_bg;
`ifdef DRAW_RECT_CHAR_BG_EN
    exp_bg = 12'h000;
`else
    exp_bg = 12'h123;
`endif
    run_pixel(11'd32, 11'd32, 12'h123, 1'b0, 1'b0, 8'h80, seen);
    checks++;
    if (seen !== 12'hFFF) begin
      errors++;
      $display("FAIL glyph_col0: rgb=%h, want fff", seen);
    end
    run_pixel(11'd33, 11'd32, 12'h123, 1'b0, 1'b0, 8'h80, seen);
    checks++;
    if (seen !== exp_bg) begin
      errors++;
      $display("FAIL glyph_col1_bg: rgb=%h, want %h", seen, exp_bg);
    end
  endtask

  task automatic test_boundaries();
    logic [11:0] seen;
    logic [10:0] bh [0:6];
    logic [10:0] bv [0:6];
    logic [11:0] be [0:6];
    // inside edges, then one pixel outside on each side
    bh[0] = 11'd159; bv[0] = 11'd100; be[0] = 12'hFFF;
    bh[1] = 11'd40;  bv[1] = 11'd287; be[1] = 12'hFFF;
    bh[2] = 11'd160; bv[2] = 11'd100; be[2] = 12'h5A3;
    bh[3] = 11'd40;  bv[3] = 11'd288; be[3] = 12'h5A3;
    bh[4] = 11'd31;  bv[4] = 11'd100; be[4] = 12'h5A3;
    bh[5] = 11'd40;  bv[5] = 11'd31;  be[5] = 12'h5A3;
    bh[6] = 11'd32;  bv[6] = 11'd32;  be[6] = 12'hFFF;
    for (int i = 0; i < 7; i++) begin
      run_pixel(bh[i], bv[i], 12'h5A3, 1'b0, 1'b0, 8'hFF, seen);
      checks++;
      if (seen !== be[i]) begin
        errors++;
        $display("FAIL boundary_%0d (h=%0d v=%0d): rgb=%h, want %h", i, bh[i], bv[i], seen, be[i]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [11:0] seen;
    run_pixel(11'd40, 11'd40, 12'h000, 1'b1, 1'b0, 8'hFF, seen);
    checks++;
    if (seen !== 12'h000) begin
      errors++;
      $display("FAIL hblnk_black: rgb=%h, want 000", seen);
    end
    run_pixel(11'd40, 11'd40, 12'h5A3, 1'b1, 1'b0, 8'hFF, seen);
    checks++;
    if (seen !== 12'h5A3) begin
      errors++;
      $display("FAIL hblnk_pass: rgb=%h, want 5a3", seen);
    end
    run_pixel(11'd40, 11'd40, 12'h5A3, 1'b0, 1'b1, 8'hFF, seen);
    checks++;
    if (seen !== 12'h5A3) begin
      errors++;
      $display("FAIL vblnk_pass: rgb=%h, want 5a3", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pat;
    logic [11:0] exp_rgb;
    int          j;
    pat         = 8'hA5;
    char_pixels = pat;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        hcount_in = 11'd32 + 11'(i);
        vcount_in = 11'd40;
        rgb_in    = 12'h100 + 12'(i);
      end else begin
        set_idle();
      end
      tick();
      j = i - 3;
      if (j >= 0) begin
`ifdef DRAW_RECT_CHAR_BG_EN
        exp_rgb = pat[7 - j] ? 12'hFFF : 12'h000;
`else
        exp_rgb = pat[7 - j] ? 12'hFFF : 12'h100 + 12'(j);
`endif
        checks++;
        if ({hcount_out, rgb_out} !== {11'd32 + 11'(j), exp_rgb}) begin
          errors++;
          $display("FAIL stream_px%0d: hc=%0d rgb=%h, want %0d/%h",
                   j, hcount_out, rgb_out, 32 + j, exp_rgb);
        end
      end
    end
    char_pixels = 8'h00;
    repeat (4) tick();
  endtask

  task automatic test_mid_reset();
    hcount_in   = 11'd40;
    vcount_in   = 11'd40;
    rgb_in      = 12'h777;
    char_pixels = 8'hFF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({hcount_out, rgb_out} !== {11'd0, 12'h000}) begin
        errors++;
        $display("FAIL midreset_flush_%0d: hc=%0d rgb=%h, want 0/000", k, hcount_out, rgb_out);
      end
    end
    tick();
    checks++;
    if ({hcount_out, rgb_out} !== {11'd40, 12'hFFF}) begin
      errors++;
      $display("FAIL midreset_first: hc=%0d rgb=%h, want 40/fff", hcount_out, rgb_out);
    end
    set_idle();
    char_pixels = 8'h00;
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    rst         = 1'b1;
    char_pixels = 8'h00;
    set_idle();
    test_reset();
    test_char_addr();
    test_passthrough();
    test_glyph();
    test_boundaries();
    test_blanking();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
